lzs_copy_engine: RTL and testbench
==================================

Name: lzs_copy_engine

Overview:
- Decode-side back end of the LZS decompressor.
- Accepts parsed tokens (literal, match, end) from the bitstream parser and expands matches by reading earlier bytes from history_mem over its de_* port.
- Writes every produced byte back into history_mem and presents it on a valid/ready byte stream to the DMA write path.

Parameters:
- AW, 11, history address width (2048-byte window).
- LW, 12, match length counter width.

Ports:
- wb_clk_i  input  1  system clock
- wb_rst_i  input  1  reset, asynchronous, active-low
- clr  input  1  synchronous clear of write pointer and FSM (start of new stream)
- tok_valid  input  1  token valid
- tok_ready  output  1  token accepted this cycle when tok_valid&tok_ready
- tok_type  input  2  0=literal, 1=match, 2=end, 3=reserved
- tok_lit  input  8  literal byte
- tok_off  input  AW  match offset, 1..2047 (0 illegal)
- tok_len  input  LW  match length, 1..4095 (0 illegal)
- de_hraddr  output  AW  history read address
- de_hwaddr  output  AW  history write address (= write pointer wp)
- de_hwe  output  1  history write enable
- de_data  output  8  history write data
- de_hdata  input  8  history read data, valid one cycle after de_hraddr is presented
- out_valid  output  1  output byte valid
- out_ready  input  1  downstream accepts byte
- out_data  output  8  output byte
- done  output  1  one-cycle pulse when end token is consumed
- err  output  1  sticky illegal-token flag; cleared by clr or reset
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (wb_rst_i=0, asynchronous):
  - state=IDLE; wp=0, rp=0, cnt=0, byte_r=0.
  - All outputs 0, except de_hwaddr=0 and de_hraddr=0.
- clr (synchronous) has the same effect as reset except that it does not depend on wb_rst_i. It has priority over all FSM activity, including mid-match.
- tok_ready=1 only in IDLE.
- IDLE, token handshake:
  - literal: byte_r<=tok_lit -> EMIT.
  - match with off!=0 and len!=0: rp<=wp-off (mod 2^AW), cnt<=len -> RD.
  - end: done=1 for one cycle; wp unchanged; stay IDLE.
  - reserved type, off==0 or len==0: err<=1; token dropped; stay IDLE.
- RD: de_hraddr=rp -> CAP.
- CAP: de_hraddr held at rp; byte_r<=de_hdata -> EMIT.
- EMIT:
  - out_valid=1, out_data=byte_r; de_data=byte_r.
  - de_hwe = out_valid & out_ready. History write and output acceptance happen in the same cycle, exactly once per byte.
  - On handshake: wp<=wp+1 (wraps 2047->0).
  - If the byte came from a literal -> IDLE.
  - If from a match: cnt<=cnt-1 and rp<=rp+1 (wraps). If cnt==1 -> IDLE, else -> RD.
  - With out_ready low: hold all state; out_data stable; no write.
- Throughput: literal 2 cycles/byte (IDLE+EMIT); match 3 cycles/byte plus 1 token cycle.
- Overlap:
  - Because each write completes before the next read is issued, overlapping matches are correct, e.g. off=1 replicates the last byte.
  - rp never equals wp during RD/CAP when off>=1, so the history_mem read/write bypass path is never exercised.
- Offset > bytes written so far is not checked; stale or zero history is copied.
- busy=0 only in IDLE.
- err stays set until clr.

Test Plan:
- Reset, then literals 0x41,0x42,0x43 with out_ready=1 -> out_data 41,42,43; de_hwe at wp 0,1,2; wp=3; 2 cycles per byte.
- After the above, match off=3 len=5 -> out 41,42,43,41,42; reads at addresses 0,1,2,3,4; wp=8; 3 cycles per byte.
- Literal 0x5A then match off=1 len=4 -> out 5A,5A,5A,5A,5A (overlap replicate).
- Match with out_ready held low 10 cycles in EMIT -> out_data stable, de_hwe=0, no wp change; byte written once on release.
- Preload wp=2046 via 2046 literals, then match off=2 len=4 -> writes at 2046,2047,0,1; reads at 2044,2045,2046,2047 (wrap).
- tok_off=0 -> err=1, no output; end token -> done pulse 1 cycle; clr mid-match (cnt=3) -> IDLE, wp=0, err=0, out_valid=0 next cycle.

Source files
------------

// File: rtl/lzs_copy_engine.sv
// LZS decode back end: expands literal/match tokens into a byte stream and
// mirrors every produced byte into the history window.
module lzs_copy_engine #(
  parameter int AW = 11,
  parameter int LW = 12
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          clr,
  input  logic          tok_valid,
  output logic          tok_ready,
  input  logic [1:0]    tok_type,
  input  logic [7:0]    tok_lit,
  input  logic [AW-1:0] tok_off,
  input  logic [LW-1:0] tok_len,
  output logic [AW-1:0] de_hraddr,
  output logic [AW-1:0] de_hwaddr,
  output logic          de_hwe,
  output logic [7:0]    de_data,
  input  logic [7:0]    de_hdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          done,
  output logic          err,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, RD, CAP, EMIT} state_t;

  state_t        state;
  logic [AW-1:0] wp, rp;
  logic [LW-1:0] cnt;
  logic [7:0]    byte_r;
  logic          from_match;
  logic          run;       // keeps tok_ready low for the cycle of reset/clr
  logic          out_hs;

  assign tok_ready = run & (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == EMIT);
  assign out_data  = byte_r;
  assign de_data   = byte_r;
  assign de_hwaddr = wp;
  assign de_hraddr = rp;
  assign out_hs    = out_valid & out_ready;
  assign de_hwe    = out_hs;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state      <= IDLE;
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      byte_r     <= '0;
      from_match <= 1'b0;
      run        <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else if (clr) begin
      state      <= IDLE;
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      byte_r     <= '0;
      from_match <= 1'b0;
      run        <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      run  <= 1'b1;
      done <= 1'b0;
      case (state)
        IDLE: if (tok_valid && tok_ready) begin
          case (tok_type)
            2'd0: begin
              byte_r     <= tok_lit;
              from_match <= 1'b0;
              state      <= EMIT;
            end
            2'd1: begin
              if (tok_off == '0 || tok_len == '0) begin
                err <= 1'b1;
              end else begin
                rp         <= wp - tok_off;
                cnt        <= tok_len;
                from_match <= 1'b1;
                state      <= RD;
              end
            end
            2'd2:    done <= 1'b1;
            default: err  <= 1'b1;
          endcase
        end
        RD:  state <= CAP;
        CAP: begin
          byte_r <= de_hdata;
          state  <= EMIT;
        end
        EMIT: if (out_ready) begin
          // previous byte is committed to history before the next read issues,
          // so overlapping copies see their own output
          wp <= wp + AW'(1);
          if (from_match) begin
            cnt   <= cnt - LW'(1);
            rp    <= rp + AW'(1);
            state <= (cnt == LW'(1)) ? IDLE : RD;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lzs_copy_engine.sv
// Bench for lzs_copy_engine: history memory model, token driver, and a
// queue-based reference of expected output bytes checked every cycle.
module tb_lzs_copy_engine;
  logic        clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
  logic        tok_valid = 1'b0, tok_ready;
  logic [1:0]  tok_type = '0;
  logic [7:0]  tok_lit = '0;
  logic [10:0] tok_off = '0;
  logic [11:0] tok_len = '0;
  logic [10:0] de_hraddr, de_hwaddr;
  logic        de_hwe;
  logic [7:0]  de_data, de_hdata;
  logic        out_valid, out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        done, err, busy;

  lzs_copy_engine #(.AW(11), .LW(12)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .clr(clr),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_type(tok_type),
    .tok_lit(tok_lit), .tok_off(tok_off), .tok_len(tok_len),
    .de_hraddr(de_hraddr), .de_hwaddr(de_hwaddr), .de_hwe(de_hwe),
    .de_data(de_data), .de_hdata(de_hdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .done(done), .err(err), .busy(busy));

  always #5 clk = ~clk;

  // history_mem: synchronous read, synchronous write
  logic [7:0] mem [2048];
  initial for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    de_hdata <= mem[de_hraddr];
    if (de_hwe) mem[de_hwaddr] <= de_data;
  end

  typedef struct {
    logic [7:0]  d;
    logic [10:0] wa;
    logic [10:0] ra;
    bit          m;
    int          gap;
    logic [7:0]  old;
  } exp_t;

  int          n_chk = 0, n_fail = 0;
  exp_t        exp_q[$];
  logic [7:0]  ref_hist [2048];
  logic [10:0] m_wp = '0;
  logic        m_err = 1'b0;
  int          rdy_mode = 0;   // 0: ready high, 1: ready low, 2: random
  int          lit_gap = 0;
  bit          chk_en = 1'b0;
  logic [7:0]  obs_d[$];
  logic [10:0] obs_wa[$], obs_ra[$];

  initial for (int i = 0; i < 2048; i++) ref_hist[i] = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push_lit(input logic [7:0] b, input int gap);
    exp_t e;
    e.d = b; e.wa = m_wp; e.ra = '0; e.m = 1'b0; e.gap = gap; e.old = ref_hist[m_wp];
    ref_hist[m_wp] = b;
    m_wp = m_wp + 11'd1;
    exp_q.push_back(e);
  endtask

  task automatic push_match(input logic [10:0] off, input logic [11:0] len);
    exp_t e;
    logic [10:0] src;
    src = m_wp - off;
    for (int i = 0; i < int'(len); i++) begin
      e.d = ref_hist[src]; e.wa = m_wp; e.ra = src; e.m = 1'b1;
      e.gap = (i > 0 && rdy_mode == 0) ? 3 : 0;
      e.old = ref_hist[m_wp];
      ref_hist[m_wp] = e.d;
      m_wp = m_wp + 11'd1;
      src = src + 11'd1;
      exp_q.push_back(e);
    end
  endtask

  // out_ready is driven only here
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  int cyc = 0, last_hs = 0;
  always @(negedge clk) begin
    if (rst_n && !clr && chk_en) begin
      exp_t e;
      cyc++;
      chk("hwe_vs_handshake", de_hwe, out_valid & out_ready);
      chk("busy_and_ready_exclusive", busy & tok_ready, 1'b0);
      chk("err_flag", err, m_err);
      if (out_valid) chk("out_valid_with_pending", exp_q.size() > 0, 1'b1);
      if (out_valid && exp_q.size() > 0) begin
        e = exp_q[0];
        chk("out_data", out_data, e.d);
        chk("wr_addr", de_hwaddr, e.wa);
        if (e.m) chk("rd_addr", de_hraddr, e.ra);
        if (out_ready) begin
          void'(exp_q.pop_front());
          if (e.gap != 0) chk("byte_gap", cyc - last_hs, e.gap);
          last_hs = cyc;
          obs_d.push_back(out_data);
          obs_wa.push_back(de_hwaddr);
          obs_ra.push_back(de_hraddr);
        end
      end
    end
  end

  task automatic send(input logic [1:0] ty, input logic [7:0] lit,
                      input logic [10:0] off, input logic [11:0] len);
    int n = 0;
    tok_type = ty; tok_lit = lit; tok_off = off; tok_len = len; tok_valid = 1'b1;
    while (!tok_ready && n < 3000) begin @(posedge clk); #1; n++; end
    if (!tok_ready) begin
      chk("tok_ready_timeout", 1'b0, 1'b1);
      tok_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    tok_valid = 1'b0;
    case (ty)
      2'd0: push_lit(lit, lit_gap);
      2'd1: if (off == '0 || len == '0) m_err = 1'b1; else push_match(off, len);
      2'd2: chk("done_pulse", done, 1'b1);
      default: m_err = 1'b1;
    endcase
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 20000) begin @(posedge clk); #1; n++; end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_obs();
    obs_d.delete(); obs_wa.delete(); obs_ra.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] l1, l2, lr;
  logic [10:0] hw_hold;
  initial begin
    // reset state
    #23;
    chk("rst_tok_ready", tok_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_de_hwe", de_hwe, 1'b0);
    chk("rst_de_data", de_data, 8'h00);
    chk("rst_hwaddr", de_hwaddr, 11'd0);
    chk("rst_hraddr", de_hraddr, 11'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    cycles(2);

    // literals A,B,C at 2 cycles/byte
    clear_obs();
    lit_gap = 0; send(2'd0, 8'h41, '0, '0);
    lit_gap = 2; send(2'd0, 8'h42, '0, '0);
    send(2'd0, 8'h43, '0, '0);
    lit_gap = 0;
    drain();
    chk("lit_d0", obs_d[0], 8'h41); chk("lit_d1", obs_d[1], 8'h42); chk("lit_d2", obs_d[2], 8'h43);
    chk("lit_wa0", obs_wa[0], 11'd0); chk("lit_wa2", obs_wa[2], 11'd2);
    chk("wp_after_lits", de_hwaddr, 11'd3);

    // match off=3 len=5
    clear_obs();
    send(2'd1, 8'h00, 11'd3, 12'd5);
    drain();
    chk("m_d3", obs_d[3], 8'h41); chk("m_d4", obs_d[4], 8'h42);
    chk("m_ra0", obs_ra[0], 11'd0); chk("m_ra4", obs_ra[4], 11'd4);
    chk("wp_after_match", de_hwaddr, 11'd8);

    // overlapping replicate
    clear_obs();
    send(2'd0, 8'h5A, '0, '0);
    send(2'd1, 8'h00, 11'd1, 12'd4);
    drain();
    chk("rep_count", obs_d.size(), 5);
    for (int i = 0; i < 5; i++) chk("rep_byte", obs_d[i], 8'h5A);

    // stall in EMIT
    rdy_mode = 1; cycles(2);
    send(2'd1, 8'h00, 11'd2, 12'd2);
    begin
      int n = 0;
      while (!out_valid && n < 20) begin cycles(1); n++; end
    end
    hw_hold = de_hwaddr;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_hwe", de_hwe, 1'b0);
      chk("stall_wp", de_hwaddr, hw_hold);
      chk("stall_data", out_data, 8'h5A);
    end
    rdy_mode = 0;
    drain();
    chk("wp_after_stall", de_hwaddr, 11'd15);

    // illegal tokens and end
    send(2'd1, 8'h00, 11'd0, 12'd5);
    chk("err_off0", err, 1'b1);
    send(2'd1, 8'h00, 11'd4, 12'd0);
    send(2'd3, 8'h00, 11'd1, 12'd1);
    cycles(3);
    chk("no_out_on_err", out_valid, 1'b0);
    send(2'd2, 8'h00, '0, '0);
    cycles(1);
    chk("done_one_cycle", done, 1'b0);
    chk("wp_after_end", de_hwaddr, 11'd15);

    // clr mid-match once three bytes remain
    send(2'd1, 8'h00, 11'd4, 12'd5);
    begin
      int n = 0;
      while (exp_q.size() > 3 && n < 100) begin cycles(1); n++; end
    end
    clr = 1'b1;
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_back();
      ref_hist[e.wa] = e.old;
    end
    m_wp = '0; m_err = 1'b0;
    cycles(1);
    clr = 1'b0;
    chk("clr_out_valid", out_valid, 1'b0);
    chk("clr_busy", busy, 1'b0);
    chk("clr_err", err, 1'b0);
    chk("clr_wp", de_hwaddr, 11'd0);
    cycles(2);

    // fill to wp=2046 then wrapping match
    for (int i = 0; i < 2046; i++) begin
      lr = 8'($urandom);
      send(2'd0, lr, '0, '0);
      if (i == 2044) l1 = lr;
      if (i == 2045) l2 = lr;
    end
    drain();
    chk("wp_2046", de_hwaddr, 11'd2046);
    clear_obs();
    send(2'd1, 8'h00, 11'd2, 12'd4);
    drain();
    chk("wrap_wa0", obs_wa[0], 11'd2046); chk("wrap_wa1", obs_wa[1], 11'd2047);
    chk("wrap_wa2", obs_wa[2], 11'd0);    chk("wrap_wa3", obs_wa[3], 11'd1);
    chk("wrap_ra0", obs_ra[0], 11'd2044); chk("wrap_ra3", obs_ra[3], 11'd2047);
    chk("wrap_d0", obs_d[0], l1); chk("wrap_d1", obs_d[1], l2);
    chk("wrap_d2", obs_d[2], l1); chk("wrap_d3", obs_d[3], l2);

    // randomized tokens with random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 50)      send(2'd0, 8'($urandom), '0, '0);
      else if (r < 88) send(2'd1, 8'h00, 11'($urandom_range(1, 2047)), 12'($urandom_range(1, 12)));
      else if (r < 93) send(2'd2, 8'h00, '0, '0);
      else if (r < 96) send(2'd1, 8'h00, 11'd0, 12'($urandom_range(1, 8)));
      else             send(2'd3, 8'($urandom), 11'($urandom), 12'($urandom));
    end
    rdy_mode = 0;
    drain();
    cycles(3);
    chk("final_wp", de_hwaddr, m_wp);
    chk("final_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
